// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage.
// Takes one load or store at a time, performs it after LATENCY wait cycles
// on an internal word array, and returns the result on a response channel.
// While the responder is not idle, busy requests a pipeline stall.
//
// Handshake: a transfer happens on a rising clk edge where both valid and
// ready are high. The initiator holds req_* stable while req_valid is high
// and req_ready is low. The responder holds rsp_* stable while rsp_valid is
// high and rsp_ready is low. req_ready is high only in IDLE, so the edge
// that completes a response can never also accept a new request.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_was_write,
  output logic        busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The counter is loaded with LATENCY-1 so it reaches 0 on the access edge.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] mem [DEPTH];

  logic          acc_fire;
  logic          acc_write;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_in_range;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_rdata;
  logic          mem_we;

  assign req_ready = (state == S_IDLE);
  assign busy      = ~req_ready;

  // Select the operands of the access: with zero latency the access happens
  // on the accept edge, so it uses the live request instead of the latch.
  always_comb begin
    acc_write    = lat_write;
    acc_addr     = lat_addr;
    acc_wdata    = lat_wdata;
    if (state == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_fire     = ((state == S_IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state == S_WAIT) && (cnt == 4'd0));
    // Full-width compare: out-of-range addresses must never alias into the array.
    acc_in_range = (acc_addr < 32'(DEPTH));
    acc_idx      = acc_addr[AW-1:0];
    acc_rdata    = '0;
    if (acc_in_range && !acc_write) acc_rdata = mem[acc_idx];
    mem_we       = acc_fire && acc_write && acc_in_range;
  end

  // Word array: cleared by reset, written only by an in-range store access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Request/wait/response sequencing with registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      lat_write     <= 1'b0;
      lat_addr      <= '0;
      lat_wdata     <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_was_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (LATENCY == 0) begin
              rsp_rdata     <= acc_rdata;
              rsp_err       <= ~acc_in_range;
              rsp_was_write <= acc_write;
              rsp_valid     <= 1'b1;
              state         <= S_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_rdata     <= acc_rdata;
            rsp_err       <= ~acc_in_range;
            rsp_was_write <= acc_write;
            rsp_valid     <= 1'b1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // Response data registers keep their values after the handshake.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
